// File: rtl/lut_const_multiplier.sv
// Two-stage signed fixed-point multiplier by a quasi-static coefficient.
// Stage 1 builds a 16-entry table of coefficient multiples; stage 2 sums one lookup per operand nibble.
module lut_const_multiplier #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 18,
  parameter int FRAC    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  output logic [IN_W-1:0]   result
);

  localparam int N  = IN_W / 4;
  localparam int TW = CONST_W + 4;
  localparam int SW = IN_W + CONST_W;
  localparam int UW = SW - IN_W + 1;
  localparam logic signed [SW-1:0] HALF = SW'(1) << (FRAC - 1);

  function automatic logic signed [SW-1:0] sext(input logic signed [TW-1:0] v);
    return {{(SW-TW){v[TW-1]}}, v};
  endfunction

  logic signed [TW-1:0] c_ext;
  logic signed [TW-1:0] t_d [16];
  logic signed [TW-1:0] t_q [16];
  logic [IN_W-1:0]      a_q;
  logic                 unused_b;

  assign c_ext    = {{4{b[CONST_W-1]}}, b[CONST_W-1:0]};
  assign unused_b = ^b;

  // Each entry k*C is a shift-add of C over the set bits of k.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      logic signed [TW-1:0] acc;
      // NOTE: every comb output gets a default before any conditional update, so no latch is inferred.
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        // NOTE: blocking assignments in always_comb so later statements see the updated acc.
        if (k[j]) acc = acc + (c_ext <<< j);
      end
      t_d[k] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      // NOTE: the table is a register array, not a RAM, so it can and must clear with the pipeline.
      for (int k = 0; k < 16; k++) t_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      a_q <= a;
      t_q <= t_d;
    end
  end

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] part;
  logic signed [SW-1:0] c16;
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] r;
  logic [3:0]           nib;
  logic [UW-1:0]        upper;
  logic [IN_W-1:0]      res_d;

  always_comb begin
    sum  = '0;
    part = '0;
    nib  = '0;
    c16  = sext(t_q[1]) <<< 4;
    for (int i = 0; i < N; i++) begin
      nib  = a_q[4*i +: 4];
      part = sext(t_q[nib]);
      // Top nibble carries weight -8..7, so remove 16*C when its sign bit is set.
      if (i == N - 1 && nib[3]) part = part - c16;
      sum = sum + (part <<< (4 * i));
    end
    rnd   = sum + HALF;
    r     = rnd >>> FRAC;
    upper = r[SW-1:IN_W-1];
    if ((&upper) || !(|upper)) res_d = r[IN_W-1:0];
    else if (r[SW-1])          res_d = {1'b1, {(IN_W-1){1'b0}}};
    else                       res_d = {1'b0, {(IN_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result <= '0;
    else        result <= res_d;
  end

endmodule

// File: tb/tb_lut_const_multiplier.sv
// Directed-vector bench for lut_const_multiplier at default parameters (IN_W=32, CONST_W=18, FRAC=15).
module tb_lut_const_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;

  int tests  = 0;
  int failed = 0;

  lut_const_multiplier #(.IN_W(32), .CONST_W(18), .FRAC(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    tests++;
    assert (result === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, result, exp);
    end
  endtask

  // Drive one operand pair at a falling edge and check it two rising edges later.
  task automatic single(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp);
    @(negedge clk);
    a = av;
    b = bv;
    @(negedge clk);
    @(negedge clk);
    check(tag, exp);
  endtask

  logic [31:0] sa [4] = '{32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'h00000001};

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_state", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    single("identity",        32'h12345678, 32'h00008000, 32'h12345678);
    single("neg_c_65536",     32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFE);
    single("neg_c_half_up",   32'h00004000, 32'hFFFFFFFF, 32'h00000000);
    single("neg_c_below",     32'h00003FFF, 32'hFFFFFFFF, 32'h00000000);
    single("signed_x_signed", 32'hFFFF0000, 32'h0003C000, 32'h00008000);
    single("neg1_x_neg_half", 32'hFFFFFFFF, 32'h0003C000, 32'h00000001);
    single("neg1_x_half",     32'hFFFFFFFF, 32'h00004000, 32'h00000000);
    single("sat_pos",         32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF);
    single("sat_neg",         32'h80000000, 32'h00010000, 32'h80000000);
    single("times_two",       32'h00001234, 32'h00010000, 32'h00002468);
    single("min_a_x_min_c",   32'h80000000, 32'h00020000, 32'h7FFFFFFF);
    single("upper_b_ignored", 32'h12345678, 32'hABC08000, 32'h12345678);
    single("min_a_x_one",     32'h80000000, 32'hABC08000, 32'h80000000);

    // Back-to-back stream at C=1.0 with the coefficient switching on the last operand.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        if (i - 2 == 3) check($sformatf("stream_%0d", i - 2), 32'h00000002);
        else            check($sformatf("stream_%0d", i - 2), sa[i-2]);
      end
      if (i < 4) begin
        a = sa[i];
        b = (i == 3) ? 32'h00010000 : 32'h00008000;
      end
    end

    // Fill the pipeline, then reset mid-stream.
    @(negedge clk);
    a = 32'h00001234;
    b = 32'h00010000;
    @(negedge clk);
    a = 32'h7FFFFFFF;
    @(negedge clk);
    check("pre_reset", 32'h00002468);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'h0);
    @(negedge clk);
    check("reset_held", 32'h0);
    a     = 32'h12345678;
    b     = 32'h00008000;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_edge1", 32'h0);
    a = 32'h00010000;
    b = 32'hFFFFFFFF;
    @(negedge clk);
    check("post_reset_edge2", 32'h12345678);
    @(negedge clk);
    check("post_reset_next", 32'hFFFFFFFE);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
